// File: rtl/dot_product_accumulator_pkg.sv
// Shared types, state encodings and width helpers for the dot-product
// accumulator that sits behind the pipelined multiplier.
package dot_product_accumulator_pkg;

  // Accumulator FSM: FIRST means the next valid product opens a new vector.
  typedef enum logic {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } accState_t;

  // Per-operand tag that travels alongside the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Product width for a given multiplier operand width.
  function automatic int prodWidth(input int size);
    return 2 * size;
  endfunction

  // Accumulator width: product width plus guard MSBs.
  function automatic int accWidth(input int size, input int guard);
    return 2 * size + guard;
  endfunction

  // Element counter width.
  function automatic int cntWidth(input int guard);
    return guard + 1;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Handshake/bus bundle between the operand issuer, the multiplier output
// and the dot-product accumulator.
interface dot_product_accumulator_if
  import dot_product_accumulator_pkg::*;
#(
  parameter int size  = 16,
  parameter int guard = 8
);

  localparam int PROD_W = prodWidth(size);
  localparam int ACC_W  = accWidth(size, guard);
  localparam int CNT_W  = cntWidth(guard);

  logic              enable;
  logic              in_valid;
  logic              in_last;
  logic [PROD_W-1:0] product;
  logic              out_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;
  logic              stall;
  logic              lost;

  modport master (
    output enable, in_valid, in_last, product, out_ready,
    input  out_valid, out_sum, out_count, out_overflow, stall, lost
  );

  modport slave (
    input  enable, in_valid, in_last, product, out_ready,
    output out_valid, out_sum, out_count, out_overflow, stall, lost
  );

endinterface

// File: rtl/dot_product_accumulator_tag_delay_line.sv
// Enable-gated shift register of configurable depth and width with an
// asynchronous clear; reusable for any pipeline that stalls on an enable.
module tag_delay_line #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per enabled edge; reset flushes every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_enable) begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: tags each operand pair, sums the matching
// multiplier products per vector and hands the finished sum to a
// valid/ready output register.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int size    = 16,
  parameter int latency = 16,
  parameter int guard   = 8
) (
  input logic                      clk,
  input logic                      reset,
  dot_product_accumulator_if.slave bus
);

  localparam int PROD_W = prodWidth(size);
  localparam int ACC_W  = accWidth(size, guard);
  localparam int CNT_W  = cntWidth(guard);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  accState_t        r_state;
  accState_t        w_stateNext;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [ACC_W-1:0] r_outSum;
  logic [CNT_W-1:0] r_outCount;
  logic             r_outOvf;
  logic             r_outValid;
  logic             r_lost;

  tag_t             w_inTag;
  tag_t             w_tail;
  logic             w_isFirst;
  logic [ACC_W-1:0] w_accBase;
  logic [ACC_W-1:0] w_accNew;
  logic             w_carry;
  logic [CNT_W-1:0] w_cntBase;
  logic [CNT_W-1:0] w_cntNew;
  logic             w_ovfNew;
  logic             w_fire;
  logic             w_load;
  logic             w_stall;

  // A bubble never carries a last flag, so a stray in_last cannot close a vector.
  assign w_inTag.valid = bus.in_valid;
  assign w_inTag.last  = bus.in_valid & bus.in_last;

  tag_delay_line #(
    .DEPTH (latency),
    .WIDTH (TAG_W)
  ) u_tagPipe (
    .clk      (clk),
    .reset    (reset),
    .i_enable (bus.enable),
    .i_data   (w_inTag),
    .o_data   (w_tail)
  );

  assign w_isFirst = (r_state == FIRST);
  assign w_accBase = w_isFirst ? '0 : r_acc;
  assign {w_carry, w_accNew} = {1'b0, w_accBase} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};
  assign w_cntBase = w_isFirst ? '0 : r_count;
  assign w_cntNew  = (w_cntBase == CNT_MAX) ? CNT_MAX : w_cntBase + 1'b1;
  assign w_ovfNew  = (~w_isFirst & r_ovf) | w_carry | (w_cntNew == CNT_MAX);
  assign w_fire    = bus.enable & w_tail.valid;
  assign w_load    = w_fire & w_tail.last;
  assign w_stall   = r_outValid & ~bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FIRST;
    else       r_state <= w_stateNext;
  end

  // Next state: a retired last tag closes the vector, any other valid tag keeps it open.
  always_comb begin
    w_stateNext = r_state;
    if (w_fire) begin
      w_stateNext = w_tail.last ? FIRST : ACCUM;
    end
  end

  // Running sum, element count and overflow flag of the open vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_fire) begin
      if (w_tail.last) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_acc   <= w_accNew;
        r_count <= w_cntNew;
        r_ovf   <= w_ovfNew;
      end
    end
  end

  // Output register with valid/ready; a result arriving while stalled is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outSum   <= '0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
      r_outValid <= 1'b0;
      r_lost     <= 1'b0;
    end else if (w_load && !w_stall) begin
      r_outSum   <= w_accNew;
      r_outCount <= w_cntNew;
      r_outOvf   <= w_ovfNew;
      r_outValid <= 1'b1;
    end else begin
      if (w_load) r_lost <= 1'b1;
      if (r_outValid && bus.out_ready) r_outValid <= 1'b0;
    end
  end

  assign bus.out_valid    = r_outValid;
  assign bus.out_sum      = r_outSum;
  assign bus.out_count    = r_outCount;
  assign bus.out_overflow = r_outOvf;
  assign bus.stall        = w_stall;
  assign bus.lost         = r_lost;

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream consumer of the pipelined multiplier (slow_multiplication).
- Tracks a {valid, last} tag alongside each operand pair, delayed by the multiplier latency, so every product leaving the multiplier is known to be valid or a bubble.
- Sums products into a dot product per vector and presents each finished sum through a valid/ready output register.
- Shares the multiplier's enable and exports a stall signal so the operand issuer can hold the pipeline.

Parameters:
- size, 16: multiplier operand width; product width is 2*size.
- latency, 16: multiplier depth in enabled clock edges; must equal the multiplier's size.
- guard, 8: extra accumulator MSBs; also sets the maximum vector length.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  same enable that drives the multiplier; tag pipeline and accumulator advance only when high.
- in_valid  input  1  operands presented to the multiplier this cycle are real.
- in_last  input  1  these operands are the final element of the vector; ignored when in_valid=0.
- product  input  2*size  multiplier output.
- out_ready  input  1  downstream accepts out_sum.
- out_valid  output  1  out_sum, out_count and out_overflow hold a finished result.
- out_sum  output  2*size+guard  dot-product result.
- out_count  output  guard+1  number of elements in the result.
- out_overflow  output  1  accumulator carry-out or count saturation occurred in this vector.
- stall  output  1  combinational: out_valid & ~out_ready.
- lost  output  1  sticky error: a result was dropped.

Behaviour:
- Reset:
  - All tags, acc, count, out_sum, out_count, out_overflow, out_valid and lost go to 0; the FSM goes to FIRST.
  - Asserting reset mid-vector discards the partial sum and every in-flight tag.
- Tag pipe:
  - latency-deep shift register of {valid, last}.
  - On each enabled edge it shifts, inserting {in_valid, in_valid & in_last}.
  - The tail entry is aligned with the product of the operands sampled latency enabled edges earlier.
  - While enable=0 nothing shifts.
- FSM, two states:
  - FIRST: the next valid product starts a new vector; acc is treated as 0.
  - ACCUM: a vector is in progress.
- On an enabled edge with a valid tail:
  - acc_new = (FIRST ? 0 : acc) + zero-extended product.
  - Addition wraps modulo 2^(2*size+guard); a carry-out sets the vector's overflow flag.
  - count_new = (FIRST ? 0 : count) + 1, saturating at 2^(guard+1)-1; reaching saturation also sets the overflow flag.
  - Tail last=0: acc <= acc_new, count <= count_new, state <= ACCUM.
  - Tail last=1: the output register loads {acc_new, count_new, overflow}, out_valid <= 1, acc, count and the overflow flag clear, state <= FIRST.
- Tail invalid (bubble) or enable=0: acc, count and state hold.
- Output handshake, independent of enable:
  - out_valid & out_ready, no new result: out_valid <= 0.
  - Load and out_ready both high in the same cycle: the new result replaces the old; out_valid stays 1; no loss.
  - Load while stall=1: the new result is dropped, the output register is unchanged, lost <= 1.
- lost is sticky until reset.
- The issuer must deassert enable while stall=1; the block does not gate enable itself.
- End-to-end latency:
  - out_valid rises on the enabled edge that retires the last element's tag.
  - That is latency enabled edges after in_last is sampled.
  - The result is visible in the following cycle.

Decomposition:
- Shared constants belong in the common misc_modules header:
  - PROD_W = 2*size
  - ACC_W = 2*size+guard
  - CNT_W = guard+1
  - FSM state encodings FIRST=0 and ACCUM=1.
- One sub-module, tag_delay_line: parameterised depth/width shift register with enable and async reset. It is reusable for any enable-gated pipeline in the codebase.
- The accumulator, FSM and output register stay in the top level.

Test Plan (size=4, latency=4, guard=4):
- Vector (3×5, 2×7, 15×15), enable=1, out_ready=1 -> after 4 enabled edges past in_last: out_sum=254, out_count=3, out_overflow=0, out_valid high for exactly 1 cycle.
- Single element 15×15 with in_last=1 -> out_sum=225, out_count=1; FSM back in FIRST.
- Back-to-back vectors (1×1, 2×2 last) then (3×3 last), with in_valid=0 bubbles between -> results 5/count 2, then 9/count 1; bubbles do not alter sums.
- out_ready=0 after the first result (sum 9): stall=1. Keep enable=1 so a second vector (4×4 last) completes -> lost=1, out_sum stays 9. Raise out_ready -> out_valid drops; lost stays 1 until reset.
- 19 elements of 15×15 -> out_sum=179 (4275 mod 4096), out_count=19, out_overflow=1.
- Reset pulsed after 2 of 3 elements issued, then a fresh vector 2×3 last -> out_sum=6, out_count=1; no stale partial sum or tag survives.
